// File: rtl/fetch_unit.sv
// fetch_unit: fetch PC, single-outstanding request/ack handshake to instruction memory,
// and a DEPTH-entry prefetch queue. Define FETCH_STATS_EN to enable fetch/flush counters.
module fetch_unit #(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] IAddr,
    output logic        IReq,
    input  logic        IAck,
    input  logic [31:0] IRdata,
    output logic [31:0] Instr,
    output logic [31:0] InstrPC,
    output logic [31:0] PCPlus8,
    output logic        InstrValid,
    input  logic        InstrReady,
    input  logic        PCSrc,
    input  logic [31:0] BranchTarget,
    output logic [31:0] FetchCount,
    output logic [31:0] FlushCount
);
    localparam int          AW   = $clog2(DEPTH);
    localparam logic [AW:0] FULL = DEPTH[AW:0];

    typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

    state_t        state, state_next;
    logic [31:0]   fetch_pc, fetch_pc_next, iaddr_next, target;
    logic [31:0]   mem_instr [DEPTH];
    logic [31:0]   mem_pc    [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr, rd_ptr_next;
    logic [AW:0]   count, count_after_pop, count_next;
    logic          pop, push;
    logic [31:0]   instr_next, instr_pc_next;

    always_comb begin
        // NOTE: every signal gets a default up front so no path through the block infers a latch.
        pop             = InstrValid && InstrReady;
        push            = (state == REQ) && IAck && !PCSrc;
        target          = {BranchTarget[31:2], 2'b00};
        count_after_pop = count - {{AW{1'b0}}, pop};
        count_next      = PCSrc ? '0 : count_after_pop + {{AW{1'b0}}, push};
        rd_ptr_next     = pop ? rd_ptr + AW'(1) : rd_ptr;
        fetch_pc_next   = PCSrc ? target : (push ? fetch_pc + 32'd4 : fetch_pc);

        state_next = state;
        case (state)
            IDLE: state_next = (count_next < FULL) ? REQ : IDLE;
            REQ: begin
                if (IAck)       state_next = (count_next < FULL) ? REQ : IDLE;
                else if (PCSrc) state_next = DROP;
            end
            DROP:    if (IAck) state_next = REQ;
            default: state_next = IDLE;
        endcase

        // A stale request keeps its address until acknowledged.
        iaddr_next = (state_next == DROP) ? IAddr : fetch_pc_next;

        instr_next    = Instr;
        instr_pc_next = InstrPC;
        if (count_next != '0) begin
            if (count_after_pop == '0) begin
                instr_next    = IRdata;
                instr_pc_next = fetch_pc;
            end else begin
                instr_next    = mem_instr[rd_ptr_next];
                instr_pc_next = mem_pc[rd_ptr_next];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            IReq       <= 1'b0;
            IAddr      <= RESET_PC;
            fetch_pc   <= RESET_PC;
            count      <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            InstrValid <= 1'b0;
            Instr      <= '0;
            InstrPC    <= '0;
        end else begin
            state      <= state_next;
            IReq       <= (state_next != IDLE);
            IAddr      <= iaddr_next;
            fetch_pc   <= fetch_pc_next;
            count      <= count_next;
            rd_ptr     <= PCSrc ? '0 : rd_ptr_next;
            if (PCSrc)     wr_ptr <= '0;
            else if (push) wr_ptr <= wr_ptr + AW'(1);
            InstrValid <= (count_next != '0);
            Instr      <= instr_next;
            InstrPC    <= instr_pc_next;
        end
    end

    // NOTE: queue storage has no reset; an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_instr[wr_ptr] <= IRdata;
            mem_pc[wr_ptr]    <= fetch_pc;
        end
    end

    assign PCPlus8 = InstrPC + 32'd8;

`ifdef FETCH_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            FetchCount <= '0;
            FlushCount <= '0;
        end else begin
            if (push)  FetchCount <= FetchCount + 32'd1;
            if (PCSrc) FlushCount <= FlushCount + 32'd1;
        end
    end
`else
    assign FetchCount = '0;
    assign FlushCount = '0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed cycle table, hand-written corner sequences,
// and randomized traffic compared against a queue-based reference model.
module tb_fetch_unit;
    localparam int DEPTH = 2;

    typedef struct {
        logic        ack, ready, src;
        logic [31:0] target, rdata;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_instr, e_pc;
    } vec_t;

    typedef struct {
        logic [31:0] instr, pc;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] iaddr, irdata, instr, instr_pc, pc_plus8, branch_target, fetch_count, flush_count;
    logic        ireq, iack, instr_valid, instr_ready, pc_src;

    logic        w_reset = 1'b0;
    logic [31:0] w_iaddr, w_instr, w_instr_pc, w_pc_plus8, w_fetch_count, w_flush_count;
    logic        w_ireq, w_instr_valid;

    int total  = 0;
    int passed = 0;

    // Reference model state
    ent_t        m_q[$];
    logic [31:0] m_pc, m_addr;
    logic        m_req, m_stale;

    always #5 clk = ~clk;

    fetch_unit #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) u_dut (
        .clk(clk), .reset(reset), .IAddr(iaddr), .IReq(ireq), .IAck(iack), .IRdata(irdata),
        .Instr(instr), .InstrPC(instr_pc), .PCPlus8(pc_plus8), .InstrValid(instr_valid),
        .InstrReady(instr_ready), .PCSrc(pc_src), .BranchTarget(branch_target),
        .FetchCount(fetch_count), .FlushCount(flush_count)
    );

    fetch_unit #(.DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)) u_wrap (
        .clk(clk), .reset(w_reset), .IAddr(w_iaddr), .IReq(w_ireq), .IAck(1'b1),
        .IRdata(32'h1234_5678), .Instr(w_instr), .InstrPC(w_instr_pc), .PCPlus8(w_pc_plus8),
        .InstrValid(w_instr_valid), .InstrReady(1'b1), .PCSrc(1'b0), .BranchTarget(32'h0),
        .FetchCount(w_fetch_count), .FlushCount(w_flush_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic step(input logic a, input logic r, input logic s,
                        input logic [31:0] t, input logic [31:0] d);
        iack = a; instr_ready = r; pc_src = s; branch_target = t; irdata = d;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        iack = 1'b0; instr_ready = 1'b0; pc_src = 1'b0; branch_target = '0; irdata = '0;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    function automatic vec_t v(input logic a, input logic r, input logic [31:0] d,
                               input logic er, input logic [31:0] ea, input logic ev,
                               input logic [31:0] ei, input logic [31:0] ep);
        vec_t x;
        x.ack = a; x.ready = r; x.src = 1'b0; x.target = '0; x.rdata = d;
        x.e_req = er; x.e_addr = ea; x.e_valid = ev; x.e_instr = ei; x.e_pc = ep;
        return x;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_pc = 32'h0; m_addr = 32'h0; m_req = 1'b0; m_stale = 1'b0;
    endtask

    // Advances the model across one clock edge using the inputs currently driven.
    task automatic model_step();
        logic do_pop, do_push;
        ent_t e;
        do_pop  = (m_q.size() > 0) && instr_ready;
        do_push = m_req && iack && !m_stale && !pc_src;
        if (pc_src) m_q.delete();
        else begin
            if (do_pop) void'(m_q.pop_front());
            if (do_push) begin
                e.instr = irdata; e.pc = m_pc;
                m_q.push_back(e);
            end
        end
        if (pc_src)       m_pc = {branch_target[31:2], 2'b00};
        else if (do_push) m_pc = m_pc + 32'd4;
        if (m_req && !iack) begin
            if (pc_src) m_stale = 1'b1;
        end else begin
            m_stale = 1'b0;
            m_req   = (m_q.size() < DEPTH);
            m_addr  = m_pc;
        end
    endtask

    task automatic model_compare();
        check("rnd_ireq", {31'b0, ireq}, {31'b0, m_req});
        if (m_req) check("rnd_iaddr", iaddr, m_addr);
        check("rnd_valid", {31'b0, instr_valid}, {31'b0, (m_q.size() > 0)});
        if (m_q.size() > 0) begin
            check("rnd_instr", instr, m_q[0].instr);
            check("rnd_pc", instr_pc, m_q[0].pc);
            check("rnd_pc8", pc_plus8, m_q[0].pc + 32'd8);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
        $fatal(1);
    end

    initial begin
        vec_t vecs[12];
        int   ack_pct[3]   = '{50, 90, 100};
        int   ready_pct[3] = '{80, 30, 100};
        int   src_pct[3]   = '{8, 5, 3};

        vecs[0]  = v(1, 1, 32'hA000_0000, 1, 32'h00, 0, 32'h0, 32'h0);
        vecs[1]  = v(1, 1, 32'hA000_0000, 1, 32'h04, 1, 32'hA000_0000, 32'h00);
        vecs[2]  = v(1, 1, 32'hA000_0001, 1, 32'h08, 1, 32'hA000_0001, 32'h04);
        vecs[3]  = v(1, 1, 32'hA000_0002, 1, 32'h0C, 1, 32'hA000_0002, 32'h08);
        vecs[4]  = v(1, 0, 32'hA000_0003, 0, 32'h00, 1, 32'hA000_0002, 32'h08);
        vecs[5]  = v(1, 0, 32'h5555_5555, 0, 32'h00, 1, 32'hA000_0002, 32'h08);
        vecs[6]  = v(1, 0, 32'h5555_5555, 0, 32'h00, 1, 32'hA000_0002, 32'h08);
        vecs[7]  = v(1, 0, 32'h5555_5555, 0, 32'h00, 1, 32'hA000_0002, 32'h08);
        vecs[8]  = v(1, 0, 32'h5555_5555, 0, 32'h00, 1, 32'hA000_0002, 32'h08);
        vecs[9]  = v(1, 1, 32'h5555_5555, 1, 32'h10, 1, 32'hA000_0003, 32'h0C);
        vecs[10] = v(0, 1, 32'h5555_5555, 1, 32'h10, 0, 32'h0, 32'h0);
        vecs[11] = v(1, 1, 32'hA000_0004, 1, 32'h14, 1, 32'hA000_0004, 32'h10);

        // Reset state
        do_reset();
        check("rst_ireq", {31'b0, ireq}, 32'd0);
        check("rst_valid", {31'b0, instr_valid}, 32'd0);
        check("rst_iaddr", iaddr, 32'h0);
        check("rst_instr", instr, 32'h0);
        check("rst_pc", instr_pc, 32'h0);
        check("rst_pc8", pc_plus8, 32'h8);
        check("rst_fetch_cnt", fetch_count, 32'h0);
        check("rst_flush_cnt", flush_count, 32'h0);

        // Streaming, stall for 5 cycles, release
        for (int i = 0; i < 12; i++) begin
            step(vecs[i].ack, vecs[i].ready, vecs[i].src, vecs[i].target, vecs[i].rdata);
            check($sformatf("vec%0d_ireq", i), {31'b0, ireq}, {31'b0, vecs[i].e_req});
            if (vecs[i].e_req) check($sformatf("vec%0d_iaddr", i), iaddr, vecs[i].e_addr);
            check($sformatf("vec%0d_valid", i), {31'b0, instr_valid}, {31'b0, vecs[i].e_valid});
            if (vecs[i].e_valid) begin
                check($sformatf("vec%0d_instr", i), instr, vecs[i].e_instr);
                check($sformatf("vec%0d_pc", i), instr_pc, vecs[i].e_pc);
                check($sformatf("vec%0d_pc8", i), pc_plus8, vecs[i].e_pc + 32'd8);
            end
        end

        // Redirect while waiting for a delayed ack
        do_reset();
        step(0, 1, 0, 32'h0, 32'h0);
        step(0, 1, 1, 32'h100, 32'h0);
        check("drop_hold0", iaddr, 32'h0);
        step(0, 1, 0, 32'h0, 32'h0);
        step(0, 1, 0, 32'h0, 32'h0);
        check("drop_hold2", iaddr, 32'h0);
        check("drop_ireq", {31'b0, ireq}, 32'd1);
        step(1, 1, 0, 32'h0, 32'hDEAD_DEAD);
        check("drop_new_addr", iaddr, 32'h100);
        check("drop_discard", {31'b0, instr_valid}, 32'd0);
        step(1, 1, 0, 32'h0, 32'hB000_0000);
        check("drop_first_valid", {31'b0, instr_valid}, 32'd1);
        check("drop_first_pc", instr_pc, 32'h100);
        check("drop_first_instr", instr, 32'hB000_0000);

        // Redirect coinciding with ack, unaligned target
        do_reset();
        step(0, 0, 0, 32'h0, 32'h0);
        step(1, 0, 0, 32'h0, 32'hC000_0000);
        check("same_pre_valid", {31'b0, instr_valid}, 32'd1);
        step(1, 0, 1, 32'h203, 32'hC000_0001);
        check("same_flush", {31'b0, instr_valid}, 32'd0);
        check("same_iaddr", iaddr, 32'h200);
        check("same_ireq", {31'b0, ireq}, 32'd1);
        step(1, 1, 0, 32'h0, 32'hC000_0002);
        check("same_next_pc", instr_pc, 32'h200);
        check("same_next_instr", instr, 32'hC000_0002);

        // Address wrap on an instance reset to 0xFFFF_FFF8
        w_reset = 1'b0;
        @(posedge clk); #1;
        check("wrap_rst_iaddr", w_iaddr, 32'hFFFF_FFF8);
        check("wrap_rst_ireq", {31'b0, w_ireq}, 32'd0);
        w_reset = 1'b1;
        @(posedge clk); #1;
        check("wrap_a0", w_iaddr, 32'hFFFF_FFF8);
        check("wrap_req", {31'b0, w_ireq}, 32'd1);
        @(posedge clk); #1;
        check("wrap_a1", w_iaddr, 32'hFFFF_FFFC);
        check("wrap_pc0", w_instr_pc, 32'hFFFF_FFF8);
        check("wrap_pc8_0", w_pc_plus8, 32'h0);
        @(posedge clk); #1;
        check("wrap_a2", w_iaddr, 32'h0);
        check("wrap_pc8_1", w_pc_plus8, 32'h4);
        @(posedge clk); #1;
        check("wrap_pc2", w_instr_pc, 32'h0);
        check("wrap_pc8_2", w_pc_plus8, 32'h8);
        check("wrap_instr", w_instr, 32'h1234_5678);

        // Statistics: 3 fetches then 1 flush
        do_reset();
        step(0, 1, 0, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++) step(1, 1, 0, 32'h0, 32'h0);
        step(0, 1, 1, 32'h40, 32'h0);
`ifdef FETCH_STATS_EN
        check("stats_fetch", fetch_count, 32'd3);
        check("stats_flush", flush_count, 32'd1);
`else
        check("stats_fetch_off", fetch_count, 32'd0);
        check("stats_flush_off", flush_count, 32'd0);
`endif

        // Asynchronous reset mid-burst
        do_reset();
        step(0, 1, 0, 32'h0, 32'h0);
        step(1, 1, 0, 32'h0, 32'h1);
        step(1, 1, 0, 32'h0, 32'h2);
        check("burst_valid", {31'b0, instr_valid}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("async_ireq", {31'b0, ireq}, 32'd0);
        check("async_valid", {31'b0, instr_valid}, 32'd0);

        // Randomized traffic against the reference model
        do_reset();
        model_reset();
        for (int p = 0; p < 3; p++) begin
            for (int c = 0; c < 600; c++) begin
                model_compare();
                iack          = ($urandom_range(99) < ack_pct[p]);
                instr_ready   = ($urandom_range(99) < ready_pct[p]);
                pc_src        = ($urandom_range(99) < src_pct[p]);
                irdata        = $urandom();
                branch_target = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | ($urandom() & 32'hF))
                                                          : $urandom();
                model_step();
                @(posedge clk);
                #1;
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage directly upstream of the ARM controller/datapath. It holds the fetch PC, runs a single-outstanding request/acknowledge handshake to instruction memory, and buffers returned words in a small prefetch queue. Each queued word is presented with its PC and PC+8 on the `Instr` outputs. A taken branch or PC write (`PCSrc`) redirects fetch to `BranchTarget`, flushes the queue and discards any in-flight response.

## Interface
- `DEPTH`, 2: prefetch queue entries; power of two, at least 2.
- `RESET_PC`, 32'h0000_0000: first fetch address after reset.
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `IAddr` out 32: instruction memory address; word aligned.
- `IReq` out 1: request valid.
- `IAck` in 1: memory accepts the request and returns `IRdata` in the same cycle.
- `IRdata` in 32: instruction word.
- `Instr` out 32: head-of-queue instruction.
- `InstrPC` out 32: address of `Instr`.
- `PCPlus8` out 32: `InstrPC` + 8 (ARM PC read value).
- `InstrValid` out 1: queue head valid.
- `InstrReady` in 1: consumer takes the head; low means stall.
- `PCSrc` in 1: redirect request.
- `BranchTarget` in 32: redirect address.
- `FetchCount` out 32: stats counter (see Configuration).
- `FlushCount` out 32: stats counter (see Configuration).

## Operation
- FSM states: IDLE, REQ, DROP.
  - IDLE: `IReq`=0.
  - REQ: `IReq`=1, `IAddr` = fetch PC.
  - DROP: `IReq`=1, `IAddr` = stale address; response is discarded.
- Request rule: once `IReq` rises, `IAddr` stays stable until the cycle `IAck`=1. A request is never withdrawn.
- The queue holds {instr, pc} pairs. Pop occurs when `InstrValid` && `InstrReady`.
- IDLE → REQ when free space > 0, where free space = DEPTH − count + pop.
- REQ with `IAck`, no redirect:
  - Push {`IRdata`, fetch PC}; fetch PC += 4.
  - Next state is REQ if space remains after push+pop, else IDLE.
- REQ with redirect, no `IAck`: fetch PC ← target; → DROP.
- REQ with redirect and `IAck` in the same cycle: response discarded; fetch PC ← target; stay REQ.
- DROP with `IAck`: discard the response; → REQ, using the already-updated fetch PC.
- DROP with a new redirect: fetch PC ← newest target; stay DROP.
- IDLE with redirect: flush; fetch PC ← target; → REQ.
- Any redirect empties the queue (count ← 0) in the same edge. Flush overrides a simultaneous pop or push.
- Arithmetic: fetch PC is modulo 2^32 and wraps from 32'hFFFF_FFFC to 0. `BranchTarget[1:0]` is ignored and forced to 0. `PCPlus8` is computed modulo 2^32.
- Outputs with an empty queue: `Instr`, `InstrPC` and `PCPlus8` hold the last head values and are don't-care; only `InstrValid` is meaningful.

## Timing
- Reset values:
  - state IDLE, `IReq`=0, `InstrValid`=0, count=0.
  - fetch PC = `RESET_PC`, `IAddr` = `RESET_PC`.
  - `Instr` = 0, `InstrPC` = 0, `PCPlus8` = 8, both counters 0.
- First `IReq` asserts in the first cycle after `reset` deasserts.
- Reset asserted mid-request drops `IReq` immediately, asynchronously. The pending response is not tracked.
- Fetch latency: `IAck` in cycle N gives `InstrValid`=1 with that word in cycle N+1.
- Throughput: with `IAck` tied high and `InstrReady` high, one instruction per cycle is sustained.
- Redirect: `PCSrc` in cycle N produces `IAddr` = target in cycle N+1. The case where N is a non-ack REQ cycle is the exception: the target is issued only after the stale request is acknowledged.
- All outputs are registered except `PCPlus8`, which is combinational from `InstrPC`.

## Configuration
- `FETCH_STATS_EN` defined:
  - `FetchCount` increments on every pushed (non-discarded) word.
  - `FlushCount` increments on every cycle with `PCSrc`=1.
  - Both counters wrap at 2^32.
- `FETCH_STATS_EN` undefined: both ports are tied to 0 and no counter flops exist.

## Test plan
- Reset, `IAck` tied 1, `InstrReady` 1 → `IAddr` sequence 0, 4, 8, …; `InstrValid` rises one cycle after the first `IAck`; `PCPlus8` = `InstrPC` + 8.
- `InstrReady`=0 for 5 cycles, `IAck`=1 → exactly DEPTH words are queued, then `IReq`=0. On release, words pop in order with no loss.
- `IAck` delayed 3 cycles, `PCSrc`=1 with target 32'h100 during the wait → old address is held until ack and its data is never seen; the next `IAddr` is 32'h100; the first valid `InstrPC` is 32'h100.
- `PCSrc` with `IAck` in the same cycle, target 32'h203 → word dropped, next `IAddr` = 32'h200, queue empty the next cycle.
- Wrap: `RESET_PC` = 32'hFFFF_FFF8 → `IAddr` FFFF_FFF8, FFFF_FFFC, 0000_0000; `PCPlus8` of the last entry = 32'h8.
- Assert `reset` low mid-burst → `IReq` and `InstrValid` go to 0 without a clock edge. With `FETCH_STATS_EN`, after 3 fetches and 1 flush the counters read 3 and 1.
